monitor_carga: RTL and testbench

- Downstream consumer of the 5-bit summed battery charge (carga_total, 0..30) produced by the charge adder.
- Filters valid samples with a 4-sample moving average.
- Classifies the averaged charge into BAJA / NORMAL / LLENA, with hysteresis and N-sample confirmation.
- Drives low-charge alarm and full-charge indicators for the battery management logic.

---
 rtl/monitor_carga.sv | 207 ++++++++++++++++++++
 tb/tb_monitor_carga.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/monitor_carga.sv
// Battery charge monitor: 4-sample moving average with hysteretic, confirmed BAJA/NORMAL/LLENA classification.
// Optional macro ALARMA_LATCH_EN: alarma_baja latches until acknowledged through ack_alarma.
module monitor_carga #(
   parameter int unsigned UMBRAL_BAJO = 8,
   parameter int unsigned UMBRAL_ALTO = 24,
   parameter int unsigned HISTERESIS  = 2,
   parameter int unsigned N_CONFIRM   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       muestra_valida,
   input  logic [4:0] carga_total,
`ifdef ALARMA_LATCH_EN
   input  logic       ack_alarma,
`endif
   output logic [4:0] carga_prom,
   output logic       prom_valido,
   output logic [1:0] estado,
   output logic       alarma_baja,
   output logic       carga_completa,
   output logic       cambio_estado
);

   localparam int unsigned CW = 5;
   localparam int unsigned SW = 7;
   localparam int unsigned KW = 3;

   localparam logic [CW-1:0] UB     = CW'(UMBRAL_BAJO);
   localparam logic [CW-1:0] UA     = CW'(UMBRAL_ALTO);
   localparam logic [CW-1:0] UB_REL = CW'(UMBRAL_BAJO + HISTERESIS);
   localparam logic [CW-1:0] UA_REL = CW'(UMBRAL_ALTO - HISTERESIS);
   localparam logic [KW-1:0] NC     = KW'(N_CONFIRM);

   typedef enum logic [1:0] {
      BAJA   = 2'b00,
      NORMAL = 2'b01,
      LLENA  = 2'b10,
      INICIO = 2'b11
   } estado_t;

   logic [CW-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
   logic [CW-1:0] prom_q, prom_d;
   logic [KW-1:0] cnt_q, cnt_d;
   logic          pv_q, pv_d;
   logic          valid_q;
   estado_t       estado_q, estado_d;
   logic [KW-1:0] conf_q, conf_d;
   logic          cand_q, cand_d;
   logic          alarma_q, alarma_d;
   logic          completa_q, completa_d;
   logic          cambio_q, cambio_d;

   logic [SW-1:0] suma_c;
   logic          eval_c;
   logic          baja_c;
   logic          llena_c;
   logic          tgt_c;
   logic [KW-1:0] paso_c;
   logic [KW-1:0] conf_inc_c;

   // Moving-average window and sample counter
   always_comb begin
      w1_d   = w1_q;
      w2_d   = w2_q;
      w3_d   = w3_q;
      prom_d = prom_q;
      cnt_d  = cnt_q;
      pv_d   = pv_q;
      suma_c = SW'(w1_q) + SW'(w2_q) + SW'(w3_q) + SW'(carga_total);
      if (muestra_valida) begin
         w1_d   = carga_total;
         w2_d   = w1_q;
         w3_d   = w2_q;
         prom_d = suma_c[SW-1:2];
         if (cnt_q != KW'(4)) begin
            cnt_d = cnt_q + KW'(1);
         end
         if (cnt_q == KW'(3)) begin
            pv_d = 1'b1;
         end
      end
   end

   assign eval_c     = valid_q & pv_q;
   assign baja_c     = (prom_q < UB);
   assign llena_c    = (prom_q >= UA);
   assign conf_inc_c = conf_q + KW'(1);

   // Classification FSM: next state, confirmation counter and registered indicators
   always_comb begin
      estado_d = estado_q;
      conf_d   = conf_q;
      cand_d   = cand_q;
      tgt_c    = llena_c;
      paso_c   = KW'(1);
      if (eval_c) begin
         case (estado_q)
            INICIO: begin
               conf_d = '0;
               if (baja_c) begin
                  estado_d = BAJA;
               end else if (llena_c) begin
                  estado_d = LLENA;
               end else begin
                  estado_d = NORMAL;
               end
            end
            NORMAL: begin
               if (baja_c || llena_c) begin
                  // a change of candidate target restarts the count at 1
                  paso_c = (conf_q != '0 && cand_q == tgt_c) ? conf_inc_c : KW'(1);
                  cand_d = tgt_c;
                  if (paso_c >= NC) begin
                     estado_d = tgt_c ? LLENA : BAJA;
                     conf_d   = '0;
                  end else begin
                     conf_d = paso_c;
                  end
               end else begin
                  conf_d = '0;
               end
            end
            BAJA: begin
               if (prom_q >= UB_REL) begin
                  if (conf_inc_c >= NC) begin
                     estado_d = NORMAL;
                     conf_d   = '0;
                  end else begin
                     conf_d = conf_inc_c;
                  end
               end else begin
                  conf_d = '0;
               end
            end
            LLENA: begin
               if (prom_q < UA_REL) begin
                  if (conf_inc_c >= NC) begin
                     estado_d = NORMAL;
                     conf_d   = '0;
                  end else begin
                     conf_d = conf_inc_c;
                  end
               end else begin
                  conf_d = '0;
               end
            end
            default: begin
               estado_d = INICIO;
               conf_d   = '0;
            end
         endcase
      end

      completa_d = (estado_d == LLENA);
      cambio_d   = (estado_d != estado_q);
`ifdef ALARMA_LATCH_EN
      alarma_d = alarma_q;
      if (estado_d == BAJA) begin
         alarma_d = 1'b1;
      end else if (ack_alarma && estado_q != BAJA) begin
         alarma_d = 1'b0;
      end
`else
      alarma_d = (estado_d == BAJA);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w1_q       <= '0;
         w2_q       <= '0;
         w3_q       <= '0;
         prom_q     <= '0;
         cnt_q      <= '0;
         pv_q       <= 1'b0;
         valid_q    <= 1'b0;
         estado_q   <= INICIO;
         conf_q     <= '0;
         cand_q     <= 1'b0;
         alarma_q   <= 1'b0;
         completa_q <= 1'b0;
         cambio_q   <= 1'b0;
      end else begin
         w1_q       <= w1_d;
         w2_q       <= w2_d;
         w3_q       <= w3_d;
         prom_q     <= prom_d;
         cnt_q      <= cnt_d;
         pv_q       <= pv_d;
         valid_q    <= muestra_valida;
         estado_q   <= estado_d;
         conf_q     <= conf_d;
         cand_q     <= cand_d;
         alarma_q   <= alarma_d;
         completa_q <= completa_d;
         cambio_q   <= cambio_d;
      end
   end

   assign carga_prom     = prom_q;
   assign prom_valido    = pv_q;
   assign estado         = estado_q;
   assign alarma_baja    = alarma_q;
   assign carga_completa = completa_q;
   assign cambio_estado  = cambio_q;

endmodule

// File: tb/tb_monitor_carga.sv
// Directed bench for monitor_carga: averaging, confirmed classification, hysteresis and async reset.
module tb_monitor_carga;

   localparam logic [1:0] E_BAJA   = 2'b00;
   localparam logic [1:0] E_NORMAL = 2'b01;
   localparam logic [1:0] E_LLENA  = 2'b10;
   localparam logic [1:0] E_INICIO = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       muestra_valida = 1'b0;
   logic [4:0] carga_total = 5'd0;
   logic [4:0] carga_prom;
   logic       prom_valido;
   logic [1:0] estado;
   logic       alarma_baja;
   logic       carga_completa;
   logic       cambio_estado;
`ifdef ALARMA_LATCH_EN
   logic       ack_alarma = 1'b0;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   monitor_carga dut (
      .clk            (clk),
      .rst            (rst),
      .muestra_valida (muestra_valida),
      .carga_total    (carga_total),
`ifdef ALARMA_LATCH_EN
      .ack_alarma     (ack_alarma),
`endif
      .carga_prom     (carga_prom),
      .prom_valido    (prom_valido),
      .estado         (estado),
      .alarma_baja    (alarma_baja),
      .carga_completa (carga_completa),
      .cambio_estado  (cambio_estado)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One valid sample, then one idle cycle so the resulting evaluation has landed in estado
   task automatic ss(input logic [4:0] v, input logic [4:0] p, input logic pv,
                     input logic [1:0] e, input string tag);
      @(negedge clk);
      muestra_valida = 1'b1;
      carga_total    = v;
      @(negedge clk);
      muestra_valida = 1'b0;
      carga_total    = 5'd0;
      chk({tag, "_prom"}, 32'(carga_prom), 32'(p));
      chk({tag, "_pv"}, 32'(prom_valido), 32'(pv));
      @(negedge clk);
      chk({tag, "_estado"}, 32'(estado), 32'(e));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // reset values
      repeat (2) @(negedge clk);
      chk("rst_prom", 32'(carga_prom), 32'd0);
      chk("rst_pv", 32'(prom_valido), 32'd0);
      chk("rst_estado", 32'(estado), 32'(E_INICIO));
      chk("rst_alarma", 32'(alarma_baja), 32'd0);
      chk("rst_completa", 32'(carga_completa), 32'd0);
      chk("rst_cambio", 32'(cambio_estado), 32'd0);
      rst = 1'b0;

      // fill window with 16: no evaluation before the 4th sample
      ss(5'd16, 5'd4,  1'b0, E_INICIO, "t1_s1");
      ss(5'd16, 5'd8,  1'b0, E_INICIO, "t1_s2");
      ss(5'd16, 5'd12, 1'b0, E_INICIO, "t1_s3");
      ss(5'd16, 5'd16, 1'b1, E_NORMAL, "t1_s4");
      chk("t1_cambio_hi", 32'(cambio_estado), 32'd1);
      @(negedge clk);
      chk("t1_cambio_lo", 32'(cambio_estado), 32'd0);

      // descent to BAJA with 3-eval confirmation
      ss(5'd3, 5'd12, 1'b1, E_NORMAL, "t2_s1");
      ss(5'd3, 5'd9,  1'b1, E_NORMAL, "t2_s2");
      ss(5'd3, 5'd6,  1'b1, E_NORMAL, "t2_s3");
      ss(5'd3, 5'd3,  1'b1, E_NORMAL, "t2_s4");
      ss(5'd3, 5'd3,  1'b1, E_BAJA,   "t2_s5");
      chk("t2_alarma", 32'(alarma_baja), 32'd1);
      chk("t2_cambio", 32'(cambio_estado), 32'd1);

      // 9 stays under the release threshold 10; 10 releases after confirmation
      ss(5'd9, 5'd4, 1'b1, E_BAJA, "t3_a1");
      ss(5'd9, 5'd6, 1'b1, E_BAJA, "t3_a2");
      ss(5'd9, 5'd7, 1'b1, E_BAJA, "t3_a3");
      ss(5'd9, 5'd9, 1'b1, E_BAJA, "t3_a4");
      ss(5'd9, 5'd9, 1'b1, E_BAJA, "t3_a5");
      ss(5'd9, 5'd9, 1'b1, E_BAJA, "t3_a6");
      ss(5'd10, 5'd9,  1'b1, E_BAJA,   "t3_b1");
      ss(5'd10, 5'd9,  1'b1, E_BAJA,   "t3_b2");
      ss(5'd10, 5'd9,  1'b1, E_BAJA,   "t3_b3");
      ss(5'd10, 5'd10, 1'b1, E_BAJA,   "t3_b4");
      ss(5'd10, 5'd10, 1'b1, E_BAJA,   "t3_b5");
      ss(5'd10, 5'd10, 1'b1, E_NORMAL, "t3_b6");
`ifdef ALARMA_LATCH_EN
      chk("t3_alarma_latched", 32'(alarma_baja), 32'd1);
      @(negedge clk);
      ack_alarma = 1'b1;
      @(negedge clk);
      ack_alarma = 1'b0;
      chk("t3_alarma_acked", 32'(alarma_baja), 32'd0);
`else
      chk("t3_alarma", 32'(alarma_baja), 32'd0);
`endif

      // idle cycles with carga_total=0 must not disturb anything
      repeat (10) @(negedge clk);
      chk("t5_idle_prom", 32'(carga_prom), 32'd10);
      chk("t5_idle_pv", 32'(prom_valido), 32'd1);
      chk("t5_idle_estado", 32'(estado), 32'(E_NORMAL));
      chk("t5_idle_cambio", 32'(cambio_estado), 32'd0);

      // q, q, non-qualifying, q, q keeps NORMAL; the third q then confirms BAJA
      ss(5'd0,  5'd7,  1'b1, E_NORMAL, "t5_q1");
      ss(5'd0,  5'd5,  1'b1, E_NORMAL, "t5_q2");
      ss(5'd30, 5'd10, 1'b1, E_NORMAL, "t5_nq");
      ss(5'd0,  5'd7,  1'b1, E_NORMAL, "t5_q3");
      ss(5'd0,  5'd7,  1'b1, E_NORMAL, "t5_q4");
      ss(5'd0,  5'd7,  1'b1, E_BAJA,   "t5_q5");
      chk("t5_alarma", 32'(alarma_baja), 32'd1);

      // asynchronous reset in the middle of a cycle
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_estado", 32'(estado), 32'(E_INICIO));
      chk("t6_alarma", 32'(alarma_baja), 32'd0);
      chk("t6_prom", 32'(carga_prom), 32'd0);
      chk("t6_pv", 32'(prom_valido), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ss(5'd20, 5'd5,  1'b0, E_INICIO, "t6_s1");
      ss(5'd20, 5'd10, 1'b0, E_INICIO, "t6_s2");
      ss(5'd20, 5'd15, 1'b0, E_INICIO, "t6_s3");
      ss(5'd20, 5'd20, 1'b1, E_NORMAL, "t6_s4");

      // rise to LLENA and hysteretic release below 22
      ss(5'd30, 5'd22, 1'b1, E_NORMAL, "t4_a1");
      ss(5'd30, 5'd25, 1'b1, E_NORMAL, "t4_a2");
      ss(5'd30, 5'd27, 1'b1, E_NORMAL, "t4_a3");
      ss(5'd30, 5'd30, 1'b1, E_LLENA,  "t4_a4");
      chk("t4_completa_hi", 32'(carga_completa), 32'd1);
      chk("t4_alarma", 32'(alarma_baja), 32'd0);
      ss(5'd21, 5'd27, 1'b1, E_LLENA,  "t4_b1");
      ss(5'd21, 5'd25, 1'b1, E_LLENA,  "t4_b2");
      ss(5'd21, 5'd23, 1'b1, E_LLENA,  "t4_b3");
      ss(5'd21, 5'd21, 1'b1, E_LLENA,  "t4_b4");
      ss(5'd21, 5'd21, 1'b1, E_LLENA,  "t4_b5");
      ss(5'd21, 5'd21, 1'b1, E_NORMAL, "t4_b6");
      chk("t4_completa_lo", 32'(carga_completa), 32'd0);

      // first-eval thresholds: 8 -> NORMAL, 24 -> LLENA, 7 -> BAJA
      do_reset();
      ss(5'd8, 5'd2, 1'b0, E_INICIO, "b8_s1");
      ss(5'd8, 5'd4, 1'b0, E_INICIO, "b8_s2");
      ss(5'd8, 5'd6, 1'b0, E_INICIO, "b8_s3");
      ss(5'd8, 5'd8, 1'b1, E_NORMAL, "b8_s4");
      do_reset();
      ss(5'd24, 5'd6,  1'b0, E_INICIO, "b24_s1");
      ss(5'd24, 5'd12, 1'b0, E_INICIO, "b24_s2");
      ss(5'd24, 5'd18, 1'b0, E_INICIO, "b24_s3");
      ss(5'd24, 5'd24, 1'b1, E_LLENA,  "b24_s4");
      chk("b24_completa", 32'(carga_completa), 32'd1);
      do_reset();
      ss(5'd7, 5'd1, 1'b0, E_INICIO, "b7_s1");
      ss(5'd7, 5'd3, 1'b0, E_INICIO, "b7_s2");
      ss(5'd7, 5'd5, 1'b0, E_INICIO, "b7_s3");
      ss(5'd7, 5'd7, 1'b1, E_BAJA,   "b7_s4");
      chk("b7_alarma", 32'(alarma_baja), 32'd1);
      chk("b7_cambio", 32'(cambio_estado), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
